// File: rtl/mode_select_pkg.sv
// Shared types and mode codes for the switch-driven display mode selector.
package mode_select_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_AB    = 2'd0;
  localparam logic [MODE_W-1:0] MODE_COINC = 2'd1;
  localparam logic [MODE_W-1:0] MODE_TDC   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BLANK = 2'd3;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/mode_select_db_sw_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_raw,
  output logic d_db
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while levels differ and is cleared on acceptance, so it never reaches wrap.
  always_comb begin
    sync1_d = d_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_db = db_q;

endmodule

// File: rtl/mode_select_db.sv
// Debounced switch-to-mode register with measurement lock, pending flag and blank output.
module mode_select_db
  import mode_select_pkg::*;
#(
  parameter int unsigned      N_SW            = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [N_SW-1:0]  RESET_MODE      = '0,
  parameter logic [N_SW-1:0]  BLANK_CODE      = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw,
  input  logic            lock,
  output logic [N_SW-1:0] mode,
  output logic            mode_change,
  output logic            pending,
  output logic            blank
);

  logic [N_SW-1:0] sw_db;

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .d_raw(sw[i]),
      .d_db (sw_db[i])
    );
  end

  state_e          state_q, state_d;
  logic [N_SW-1:0] mode_q, mode_d;
  logic            mode_change_q, mode_change_d;
  logic            pending_q, pending_d;
  logic            blank_q, blank_d;

  // Lock takes priority over a new debounced value; the update is deferred to TRACK.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    mode_change_d = 1'b0;
    pending_d     = 1'b0;
    unique case (state_q)
      TRACK: begin
        if (lock) begin
          state_d = HOLD;
        end else if (sw_db != mode_q) begin
          mode_d        = sw_db;
          mode_change_d = 1'b1;
        end
      end
      HOLD: begin
        if (!lock) begin
          state_d = TRACK;
        end else begin
          pending_d = (sw_db != mode_q);
        end
      end
      default: state_d = TRACK;
    endcase
    blank_d = (mode_d == BLANK_CODE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TRACK;
      mode_q        <= RESET_MODE;
      mode_change_q <= 1'b0;
      pending_q     <= 1'b0;
      blank_q       <= (RESET_MODE == BLANK_CODE);
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      pending_q     <= pending_d;
      blank_q       <= blank_d;
    end
  end

  assign mode        = mode_q;
  assign mode_change = mode_change_q;
  assign pending     = pending_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_mode_select_db.sv
// Directed bench for mode_select_db with a short debounce window (4 cycles).
module tb_mode_select_db;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw;
  logic       lock;
  logic [1:0] mode;
  logic       mode_change;
  logic       pending;
  logic       blank;

  int n_tests;
  int n_fail;

  mode_select_db #(
    .N_SW           (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_MODE     (2'b00),
    .BLANK_CODE     (2'b11)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .lock       (lock),
    .mode       (mode),
    .mode_change(mode_change),
    .pending    (pending),
    .blank      (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic seen_change;
  logic seen_db1;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sw      = 2'b00;
    lock    = 1'b0;
    #1;
    check("rst_mode", 32'(mode), 32'(2'b00));
    check("rst_change", 32'(mode_change), 32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    check("rst_blank", 32'(blank), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First accept: new level sampled at edge 1, mode updates at edge 7
    sw = 2'b01;
    tick(6);
    check("t1_mode_e6", 32'(mode), 32'(2'b00));
    check("t1_chg_e6", 32'(mode_change), 32'(0));
    tick(1);
    check("t1_mode_e7", 32'(mode), 32'(2'b01));
    check("t1_chg_e7", 32'(mode_change), 32'(1));
    check("t1_blank_e7", 32'(blank), 32'(0));
    tick(1);
    check("t1_chg_e8", 32'(mode_change), 32'(0));
    check("t1_mode_e8", 32'(mode), 32'(2'b01));

    // Three-cycle glitch on sw[1] must be rejected
    sw = 2'b11;
    tick(3);
    sw = 2'b01;
    seen_change = 1'b0;
    seen_db1    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen_change |= mode_change;
      seen_db1    |= dut.sw_db[1];
    end
    check("gl_change", 32'(seen_change), 32'(0));
    check("gl_db1", 32'(seen_db1), 32'(0));
    check("gl_mode", 32'(mode), 32'(2'b01));

    // Blank code
    sw = 2'b11;
    tick(6);
    check("bl_chg_e6", 32'(mode_change), 32'(0));
    check("bl_mode_e6", 32'(mode), 32'(2'b01));
    tick(1);
    check("bl_mode_e7", 32'(mode), 32'(2'b11));
    check("bl_blank_e7", 32'(blank), 32'(1));
    check("bl_chg_e7", 32'(mode_change), 32'(1));
    tick(1);
    check("bl_chg_e8", 32'(mode_change), 32'(0));

    // Change requested under lock is held pending and applied after unlock
    lock = 1'b1;
    sw   = 2'b10;
    tick(6);
    check("lk_pend_e6", 32'(pending), 32'(0));
    tick(1);
    check("lk_pend_e7", 32'(pending), 32'(1));
    check("lk_mode_e7", 32'(mode), 32'(2'b11));
    check("lk_chg_e7", 32'(mode_change), 32'(0));
    tick(3);
    check("lk_pend_hold", 32'(pending), 32'(1));
    check("lk_mode_hold", 32'(mode), 32'(2'b11));
    lock = 1'b0;
    tick(1);
    check("ul_pend", 32'(pending), 32'(0));
    check("ul_mode_u1", 32'(mode), 32'(2'b11));
    check("ul_chg_u1", 32'(mode_change), 32'(0));
    tick(1);
    check("ul_mode_u2", 32'(mode), 32'(2'b10));
    check("ul_chg_u2", 32'(mode_change), 32'(1));
    check("ul_blank_u2", 32'(blank), 32'(0));
    tick(1);
    check("ul_chg_u3", 32'(mode_change), 32'(0));

    // Asynchronous reset in the middle of a debounce
    sw = 2'b11;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("ar_mode", 32'(mode), 32'(2'b00));
    check("ar_blank", 32'(blank), 32'(0));
    check("ar_chg", 32'(mode_change), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(6);
    check("ar_mode_e6", 32'(mode), 32'(2'b00));
    tick(1);
    check("ar_mode_e7", 32'(mode), 32'(2'b11));
    check("ar_chg_e7", 32'(mode_change), 32'(1));
    check("ar_blank_e7", 32'(blank), 32'(1));

    // Return to mode 00
    sw = 2'b00;
    tick(7);
    check("z_mode", 32'(mode), 32'(2'b00));
    check("z_chg", 32'(mode_change), 32'(1));
    tick(1);

    // Toggle and restore under lock: pending pulses, no change on unlock
    lock = 1'b1;
    sw   = 2'b01;
    tick(6);
    check("tg_pend_e6", 32'(pending), 32'(0));
    sw = 2'b00;
    tick(1);
    check("tg_pend_e7", 32'(pending), 32'(1));
    check("tg_mode_e7", 32'(mode), 32'(2'b00));
    tick(5);
    check("tg_pend_e12", 32'(pending), 32'(1));
    tick(1);
    check("tg_pend_e13", 32'(pending), 32'(0));
    lock = 1'b0;
    seen_change = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      seen_change |= mode_change;
    end
    check("tg_ul_chg", 32'(seen_change), 32'(0));
    check("tg_ul_mode", 32'(mode), 32'(2'b00));
    check("tg_ul_pend", 32'(pending), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_select_db.md
Name: mode_select_db

Overview:
- Parametrised successor to the combinational switch-to-mode decoder feeding the 7-segment display mux.
- Synchronises and debounces N_SW raw slide switches and registers the resulting mode code.
- Adds a lock input so the displayed mode cannot change while a TDC/coincidence measurement is running. A request made during lock is held pending and applied on unlock.
- Emits a one-cycle change strobe and a blank flag for the display driver.

Parameters:
- N_SW, 2, number of switch inputs; mode width equals N_SW (N_SW >= 1).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a switch level (10 ms at 50 MHz); must be >= 2.
- RESET_MODE, 0, mode value loaded at reset (N_SW bits).
- BLANK_CODE, all ones (2**N_SW-1), mode code that asserts blank.
- CNT_W, $clog2(DEBOUNCE_CYCLES), derived localparam; not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- sw  in  N_SW  raw asynchronous switch levels, sw[N_SW-1] is the leftmost switch (MSB of mode)
- lock  in  1  synchronous to clk; 1 = freeze mode (measurement running)
- mode  out  N_SW  registered current mode
- mode_change  out  1  one-cycle pulse on the cycle mode takes a new value
- pending  out  1  registered; 1 while locked and debounced switches differ from mode
- blank  out  1  registered; 1 when mode == BLANK_CODE

Behaviour:
- Reset (async assert, sync release):
  - sync flops, debounced levels and debounce counters = 0.
  - mode = RESET_MODE; mode_change = 0; pending = 0; blank = (RESET_MODE == BLANK_CODE).
  - FSM = TRACK.
- Synchroniser: two-flop chain per bit; the second flop is sw_sync[i].
- Debounce, per bit, independent:
  - If sw_sync != sw_db: counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and the levels still differ: sw_db <= sw_sync and counter <= 0.
  - If sw_sync == sw_db: counter <= 0.
  - A pulse shorter than DEBOUNCE_CYCLES cycles at sw_sync is rejected.
  - The counter saturates logic-free by construction and never wraps.
- Latency: let edge 1 be the first clk edge sampling a new stable level. Then sw_db updates at edge DEBOUNCE_CYCLES+2 and mode updates at edge DEBOUNCE_CYCLES+3 (when unlocked).
- FSM states TRACK and HOLD:
  - TRACK:
    - If lock = 1: go to HOLD; mode is not updated this cycle. Lock wins over a simultaneous sw_db change.
    - Else if sw_db != mode: mode <= sw_db and mode_change <= 1.
  - HOLD:
    - mode is frozen; pending <= (sw_db != mode).
    - If lock = 0: go to TRACK and pending <= 0. The update itself happens in TRACK on the following edge, so mode changes one edge after lock is seen low.
- mode_change is never asserted in consecutive cycles for the same value. It is never asserted when the new value equals the old one.
- Switch toggled and restored while locked: pending rises, then falls once sw_db returns to mode. There is no change on unlock.
- blank is updated on the same edge as mode.
- Reset mid-debounce or mid-lock: all state is discarded. After release, a switch held high is re-debounced from scratch, and mode_change fires when it is accepted.

Decomposition:
- mode_select_pkg holds:
  - mode constants MODE_AB = 0, MODE_COINC = 1, MODE_TDC = 2, MODE_BLANK = 3 (for N_SW = 2);
  - state enum {TRACK, HOLD}.
- Sub-module sw_debounce: one bit, contains the 2-flop sync, counter and sw_db.
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst_n, d_raw, d_db.
  - Generated N_SW times.
- The top level holds the FSM and the output registers.

Test Plan (DEBOUNCE_CYCLES = 4, N_SW = 2, RESET_MODE = 0):
- Reset with sw = 2'b00, then set sw = 2'b01 at edge 1 and hold -> mode = 2'b01 with mode_change = 1 exactly at edge 7; blank = 0; mode_change = 0 at edge 8.
- sw[1] glitches high for 3 cycles, then returns low -> mode and mode_change unchanged; sw_db[1] stays 0.
- Set sw = 2'b11 and hold -> mode = 2'b11, blank = 1, single mode_change pulse.
- Hold lock = 1, then set sw = 2'b10 -> mode holds old value and pending = 1 after debounce. Drop lock -> pending = 0, and mode = 2'b10 with mode_change one edge after lock is seen low.
- Under lock, toggle sw 00 -> 01 -> 00 (each held 6 cycles) -> pending pulses 1 then 0; on unlock no mode_change.
- Assert rst_n = 0 mid-debounce while sw = 2'b11 -> mode = 0, blank = 0 immediately (async). After release, mode = 2'b11 at edge 7 after release.
